// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Parametrised 2-read/1-write register file with a dedicated link write
//   port and a per-register busy scoreboard that feeds decode stall logic.
//
//   Ports:
//     clk, rst            clock (rising edge), async active-high reset
//     rd_addr0/1          read addresses
//     rd_data0/1          combinational read data (register 0 reads 0)
//     rd_busy0/1          scoreboard busy bit of the addressed register
//     wr_en/addr/data     writeback write; also clears busy[wr_addr]
//     link_en/link_data   write to LINK_REG; also clears busy[LINK_REG]
//     rsv_en/rsv_addr     reservation (mark busy) request from decode
//     rsv_ok              reservation would be accepted this cycle
//     flush               clear every busy bit
//     busy_count          registered number of busy registers
//
//   Optional macro WRITE_BYPASS_EN: same-cycle forwarding of write/link data
//   to the read ports, and suppression of rd_busyN for a register being
//   written in that cycle.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy0,
  output logic              rd_busy1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_ok,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned       DEPTH  = 1 << ADDR_W;
  localparam int unsigned       CW     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [CW-1:0]     count_next;

  // Register storage; link is applied last so it wins a same-address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) regs[wr_addr] <= wr_data;
      if (link_en)                  regs[LINK_A]  <= link_data;
    end
  end

  // A register being retired this cycle may be re-reserved immediately.
  assign rsv_ok = !busy[rsv_addr]
                | (wr_en   && (wr_addr  == rsv_addr))
                | (link_en && (rsv_addr == LINK_A))
                | (rsv_addr == '0);

  // Clears are applied before the set so a younger reservation wins.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_en)             busy_next[wr_addr]  = 1'b0;
      if (link_en)           busy_next[LINK_A]   = 1'b0;
      if (rsv_en && rsv_ok)  busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Counting the next-state vector keeps busy_count aligned with busy.
  always_comb begin
    count_next = '0;
    for (int unsigned i = 0; i < DEPTH; i++) count_next = count_next + CW'(busy_next[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= count_next;
    end
  end

  always_comb begin
    rd_data0 = (rd_addr0 == '0) ? '0 : regs[rd_addr0];
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    rd_busy0 = busy[rd_addr0];
    rd_busy1 = busy[rd_addr1];
`ifdef WRITE_BYPASS_EN
    if (wr_en && (wr_addr == rd_addr0) && (rd_addr0 != '0)) begin
      rd_data0 = wr_data;
      rd_busy0 = 1'b0;
    end
    if (wr_en && (wr_addr == rd_addr1) && (rd_addr1 != '0)) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end
    if (link_en && (rd_addr0 == LINK_A)) begin
      rd_data0 = link_data;
      rd_busy0 = 1'b0;
    end
    if (link_en && (rd_addr1 == LINK_A)) begin
      rd_data1 = link_data;
      rd_busy1 = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table,
// async-reset and wide-parameter sequences, then randomized traffic
// checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rd_addr0, rd_addr1, wr_addr, rsv_addr;
  logic [31:0] rd_data0, rd_data1, wr_data, link_data;
  logic        rd_busy0, rd_busy1, wr_en, link_en, rsv_en, rsv_ok, flush;
  logic [5:0]  busy_count;

  // wide instance
  logic [5:0]  w_rd_addr0, w_rd_addr1, w_wr_addr, w_rsv_addr;
  logic [63:0] w_rd_data0, w_rd_data1, w_wr_data, w_link_data;
  logic        w_rd_busy0, w_rd_busy1, w_wr_en, w_link_en, w_rsv_en, w_rsv_ok, w_flush;
  logic [6:0]  w_busy_count;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_busy0(rd_busy0), .rd_busy1(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(link_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .flush(flush), .busy_count(busy_count)
  );

  regfile_scoreboard #(.DATA_W(64), .ADDR_W(6), .LINK_REG(63)) dut_w (
    .clk(clk), .rst(rst),
    .rd_addr0(w_rd_addr0), .rd_addr1(w_rd_addr1),
    .rd_data0(w_rd_data0), .rd_data1(w_rd_data1),
    .rd_busy0(w_rd_busy0), .rd_busy1(w_rd_busy1),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .link_en(w_link_en), .link_data(w_link_data),
    .rsv_en(w_rsv_en), .rsv_addr(w_rsv_addr), .rsv_ok(w_rsv_ok),
    .flush(w_flush), .busy_count(w_busy_count)
  );

  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        le;  logic [31:0] ld;
    logic        re;  logic [4:0] ra; logic fl;
    logic [4:0]  a0;  logic [4:0] a1;
    logic [31:0] e_rd0; logic [31:0] e_rd1;
    logic        e_b0; logic e_b1; logic e_ok; logic [5:0] e_cnt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] m_read(input vec_t v, input logic [4:0] a);
    logic [31:0] d;
    d = (a == 0) ? 32'h0 : m_regs[a];
`ifdef WRITE_BYPASS_EN
    if (v.le && a == 5'd31) d = v.ld;
    else if (v.we && v.wa == a && a != 0) d = v.wd;
`endif
    return d;
  endfunction

  function automatic logic m_busy_rd(input vec_t v, input logic [4:0] a);
    logic b;
    b = m_busy[a];
`ifdef WRITE_BYPASS_EN
    if ((v.we && v.wa == a) || (v.le && a == 5'd31)) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic logic m_ok(input vec_t v);
    return !m_busy[v.ra] || (v.we && v.wa == v.ra) || (v.le && v.ra == 5'd31) || (v.ra == 0);
  endfunction

  task automatic model_update(input vec_t v);
    bit ok;
    ok = m_ok(v);
    if (v.fl) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (v.we) m_busy[v.wa] = 1'b0;
      if (v.le) m_busy[31] = 1'b0;
      if (v.re && ok && v.ra != 0) m_busy[v.ra] = 1'b1;
    end
    if (v.we && v.wa != 0) m_regs[v.wa] = v.wd;
    if (v.le) m_regs[31] = v.ld;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  // Drives one cycle; checks against table values (use_tbl) or the model.
  task automatic step(input vec_t v, input bit use_tbl);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    link_en = v.le; link_data = v.ld;
    rsv_en = v.re; rsv_addr = v.ra; flush = v.fl;
    rd_addr0 = v.a0; rd_addr1 = v.a1;
    @(negedge clk);
    if (use_tbl) begin
      chk("rd_data0", 64'(rd_data0), 64'(v.e_rd0));
      chk("rd_data1", 64'(rd_data1), 64'(v.e_rd1));
      chk("rd_busy0", 64'(rd_busy0), 64'(v.e_b0));
      chk("rd_busy1", 64'(rd_busy1), 64'(v.e_b1));
      chk("rsv_ok",   64'(rsv_ok),   64'(v.e_ok));
    end else begin
      chk("rnd_rd_data0", 64'(rd_data0), 64'(m_read(v, v.a0)));
      chk("rnd_rd_data1", 64'(rd_data1), 64'(m_read(v, v.a1)));
      chk("rnd_rd_busy0", 64'(rd_busy0), 64'(m_busy_rd(v, v.a0)));
      chk("rnd_rd_busy1", 64'(rd_busy1), 64'(m_busy_rd(v, v.a1)));
      chk("rnd_rsv_ok",   64'(rsv_ok),   64'(m_ok(v)));
    end
    @(posedge clk);
    model_update(v);
    #1;
    if (use_tbl) chk("busy_count", 64'(busy_count), 64'(v.e_cnt));
    else         chk("rnd_busy_count", 64'(busy_count), 64'(m_count()));
  endtask

  function automatic logic [4:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  vec_t tbl [17];
  vec_t v;

  initial begin
    //            we wa  wd            le ld            re ra fl a0  a1  e_rd0         e_rd1         b0 b1 ok cnt
    tbl[0]  = '{0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 5,  31, 32'h0,        32'h0,        0, 0, 1, 0};
    tbl[1]  = '{1, 3,  32'hDEADBEEF, 0, 32'h0,        0, 0, 0, 5,  31, 32'h0,        32'h0,        0, 0, 1, 0};
    tbl[2]  = '{1, 0,  32'h1234,     0, 32'h0,        0, 0, 0, 3,  0,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0};
    tbl[3]  = '{1, 31, 32'h11111111, 1, 32'h00400008, 0, 0, 0, 3,  0,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0};
    tbl[4]  = '{0, 0,  32'h0,        0, 32'h0,        0, 0, 0, 31, 3,  32'h00400008, 32'hDEADBEEF, 0, 0, 1, 0};
    tbl[5]  = '{0, 0,  32'h0,        0, 32'h0,        1, 7, 0, 7,  0,  32'h0,        32'h0,        0, 0, 1, 1};
    tbl[6]  = '{0, 0,  32'h0,        0, 32'h0,        1, 7, 0, 7,  3,  32'h0,        32'hDEADBEEF, 1, 0, 0, 1};
    tbl[7]  = '{1, 7,  32'hA5,       0, 32'h0,        1, 7, 0, 3,  31, 32'hDEADBEEF, 32'h00400008, 0, 0, 1, 1};
    tbl[8]  = '{0, 0,  32'h0,        0, 32'h0,        0, 7, 0, 7,  0,  32'hA5,       32'h0,        1, 0, 0, 1};
    tbl[9]  = '{1, 7,  32'h5A,       0, 32'h0,        0, 0, 0, 3,  31, 32'hDEADBEEF, 32'h00400008, 0, 0, 1, 0};
    tbl[10] = '{0, 0,  32'h0,        0, 32'h0,        1, 1, 0, 7,  0,  32'h5A,       32'h0,        0, 0, 1, 1};
    tbl[11] = '{0, 0,  32'h0,        0, 32'h0,        1, 2, 0, 1,  0,  32'h0,        32'h0,        1, 0, 1, 2};
    tbl[12] = '{0, 0,  32'h0,        0, 32'h0,        1, 3, 0, 2,  3,  32'h0,        32'hDEADBEEF, 1, 0, 1, 3};
    tbl[13] = '{0, 0,  32'h0,        0, 32'h0,        1, 4, 1, 3,  1,  32'hDEADBEEF, 32'h0,        1, 1, 1, 0};
    tbl[14] = '{0, 0,  32'h0,        0, 32'h0,        0, 3, 0, 4,  1,  32'h0,        32'h0,        0, 0, 1, 0};
    tbl[15] = '{0, 0,  32'h0,        0, 32'h0,        1, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0, 1, 0};
    tbl[16] = '{0, 0,  32'h0,        1, 32'h1000,     0, 0, 0, 3,  5,  32'hDEADBEEF, 32'h0,        0, 0, 1, 0};

    wr_en = 0; wr_addr = 0; wr_data = 0; link_en = 0; link_data = 0;
    rsv_en = 0; rsv_addr = 0; flush = 0; rd_addr0 = 5; rd_addr1 = 31;
    w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_link_en = 0; w_link_data = 0;
    w_rsv_en = 0; w_rsv_addr = 0; w_flush = 0; w_rd_addr0 = 0; w_rd_addr1 = 0;
    model_reset();

    rst = 1'b1;
    #12;
    chk("reset_busy_count", 64'(busy_count), 64'h0);
    chk("reset_rd_data0", 64'(rd_data0), 64'h0);
    chk("reset_rsv_ok", 64'(rsv_ok), 64'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) step(tbl[i], 1'b1);

    // reserve 5, then async reset between edges
    v = '{0, 0, 32'h0, 0, 32'h0, 1, 5, 0, 3, 31, 32'h0, 32'h0, 0, 0, 0, 0};
    step(v, 1'b0);
    rd_addr0 = 5;
    #1;
    chk("pre_rst_busy5", 64'(rd_busy0), 64'h1);
    rsv_en = 0; rd_addr0 = 3; rd_addr1 = 31;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy_count", 64'(busy_count), 64'h0);
    chk("async_rst_rd_data0", 64'(rd_data0), 64'h0);
    chk("async_rst_rd_data1", 64'(rd_data1), 64'h0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // wide instance: write reg 40, link to 63, reserve 62
    w_wr_en = 1; w_wr_addr = 40; w_wr_data = 64'hFFFF_FFFF_0000_0001;
    w_link_en = 1; w_link_data = 64'hCAFE_0000_0000_BEEF;
    w_rsv_en = 1; w_rsv_addr = 62;
    @(posedge clk); #1;
    w_wr_en = 0; w_link_en = 0; w_rsv_en = 0;
    w_rd_addr0 = 40; w_rd_addr1 = 63;
    #1;
    chk("wide_rd40", w_rd_data0, 64'hFFFF_FFFF_0000_0001);
    chk("wide_link63", w_rd_data1, 64'hCAFE_0000_0000_BEEF);
    chk("wide_busy_count", 64'(w_busy_count), 64'h1);
    w_rd_addr0 = 62;
    #1;
    chk("wide_busy62", 64'(w_rd_busy0), 64'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      v.we = ($urandom_range(0, 2) == 0); v.wa = pick_addr(); v.wd = $urandom;
      v.le = ($urandom_range(0, 5) == 0); v.ld = $urandom;
      v.re = ($urandom_range(0, 1) == 0); v.ra = pick_addr();
      v.fl = ($urandom_range(0, 19) == 0);
      v.a0 = pick_addr(); v.a1 = pick_addr();
      step(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the core's 2-read/1-write register file. Adds depth/width parameters, a dedicated link write port, and a per-register busy scoreboard for multi-cycle (load/mul) results. The scoreboard drives decode-stage stall logic. Sits between decode (reads/reservations) and writeback (writes/clears).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W
LINK_REG, 31, register index written by the link port (must be < 2**ADDR_W, != 0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
rd_addr0  in  ADDR_W  read port 0 address
rd_addr1  in  ADDR_W  read port 1 address
rd_data0  out  DATA_W  read port 0 data (combinational)
rd_data1  out  DATA_W  read port 1 data (combinational)
rd_busy0  out  1  register at rd_addr0 has a pending write
rd_busy1  out  1  register at rd_addr1 has a pending write
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback address
wr_data  in  DATA_W  writeback data
link_en  in  1  link write (JAL-type) to LINK_REG
link_data  in  DATA_W  link return address
rsv_en  in  1  reserve (mark busy) request from decode
rsv_addr  in  ADDR_W  register to reserve
rsv_ok  out  1  reservation accepted this cycle (combinational)
flush  in  1  clear all busy bits (pipeline flush)
busy_count  out  ADDR_W+1  number of registers currently busy (registered)

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0; all busy bits = 0; busy_count = 0. Pending reservations are discarded.
- Register 0: reads always 0. Writes are ignored. Never busy. A reservation to register 0 has no effect, and rsv_ok = 1.
- Writes, on the clk rising edge:
  - wr_en writes wr_data to wr_addr.
  - link_en writes link_data to LINK_REG.
  - If both target LINK_REG in the same cycle, link_data wins.
- Reads: combinational, regs[rd_addrN]. Write-to-read latency is 1 cycle unless WRITE_BYPASS_EN is defined.
- Scoreboard, one busy bit per register, next-state priority (highest first):
  - rst
  - flush: all busy bits = 0. Any rsv_en in that cycle is dropped, but rsv_ok still reflects the pre-flush state.
  - set: rsv_en & rsv_ok sets busy[rsv_addr].
  - clear: wr_en clears busy[wr_addr]; link_en clears busy[LINK_REG].
  - Set beats clear on the same address in the same cycle (a younger reservation supersedes an older writeback).
- rsv_ok = !busy[rsv_addr] | (wr_en & wr_addr == rsv_addr) | (link_en & rsv_addr == LINK_REG) | (rsv_addr == 0).
  - rsv_ok is valid regardless of rsv_en.
  - A rejected reservation changes no state; decode must stall and retry.
- rd_busyN = busy[rd_addrN] (raw bit, 0 for address 0), unless modified by WRITE_BYPASS_EN.
- busy_count: registered popcount of the busy vector after the update, so it tracks the busy bits with 0 extra latency. Range 0..2**ADDR_W-1, since register 0 is never busy.
- Writes to non-busy registers are legal and clear nothing.

Optional Feature:
Macro WRITE_BYPASS_EN.
- Defined:
  - Same-cycle forwarding. If wr_en & wr_addr == rd_addrN != 0, rd_dataN = wr_data.
  - If link_en & rd_addrN == LINK_REG, rd_dataN = link_data. Link takes precedence when both hit.
  - rd_busyN is forced to 0 when a write or link to that address occurs in the same cycle.
- Not defined: reads return pre-edge register contents; rd_busyN is the raw busy bit.

Test Plan:
1. Reset then read: assert rst, release, rd_addr0=5, rd_addr1=31 -> rd_data0=0, rd_data1=0, busy_count=0, rsv_ok=1.
2. Write/read and register 0: wr_en, wr_addr=3, wr_data=0xDEADBEEF, then wr_addr=0, wr_data=0x1234 -> next cycle rd_addr0=3 gives 0xDEADBEEF, rd_addr1=0 gives 0. With WRITE_BYPASS_EN, rd_addr0=3 shows 0xDEADBEEF in the write cycle itself.
3. Link priority: wr_en to 31 with 0x11111111 and link_en with 0x00400008 in the same cycle -> reg 31 = 0x00400008.
4. Scoreboard: rsv_en to 7 -> busy_count=1, rd_busy0=1 at addr 7.
   - Second rsv to 7 -> rsv_ok=0, busy_count stays 1.
   - wr_en to 7 with rsv_en to 7 in the same cycle -> rsv_ok=1, busy stays 1.
   - Plain wr_en to 7 -> busy_count=0.
5. Flush and async reset: reserve registers 1, 2, 3 (busy_count=3), assert flush together with rsv to 4 -> busy_count=0, reg 4 not busy. Reserve 5, then pulse rst mid-cycle (between edges) -> busy_count=0 and all data=0 immediately.
6. Parameter sweep: DATA_W=64, ADDR_W=6, LINK_REG=63 -> write 0xFFFF_FFFF_0000_0001 to reg 40, read back; link writes land in reg 63; busy_count width 7.
